// File: rtl/nn_weight_loader.sv
// nn_weight_loader
// Streams the network weight/bias image from a flat word stream onto the
// shared layer configuration bus. For each layer L = 1..NL and each neuron
// n = 0..NN_L-1, the stream carries NW_L weight words followed by one bias
// word. Every accepted word is presented one cycle later as a single-cycle
// weightValid/biasValid strobe, tagged with its layer/neuron.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   start, abort              : one-cycle control pulses
//   cfg_in_data/valid/ready   : input word stream (valid/ready handshake)
//   config_layer_num          : target layer (1-based) of the last strobe
//   config_neuron_num         : target neuron (0-based) of the last strobe
//   weightValue/weightValid   : weight word and its strobe
//   biasValue/biasValid       : bias word and its strobe
//   busy, done, aborted       : load in progress, completion pulse, sticky cancel
module nn_weight_loader #(
  parameter int NL  = 4,
  parameter int NN1 = 30,
  parameter int NW1 = 784,
  parameter int NN2 = 30,
  parameter int NW2 = 30,
  parameter int NN3 = 10,
  parameter int NW3 = 30,
  parameter int NN4 = 10,
  parameter int NW4 = 10,
  parameter int DW  = 32
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_in_data,
  input  logic          cfg_in_valid,
  output logic          cfg_in_ready,
  output logic [31:0]   config_layer_num,
  output logic [31:0]   config_neuron_num,
  output logic [DW-1:0] weightValue,
  output logic          weightValid,
  output logic [DW-1:0] biasValue,
  output logic          biasValid,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int MAXNW = max4(NW1, NW2, NW3, NW4);
  localparam int MAXNN = max4(NN1, NN2, NN3, NN4);
  localparam int WCW   = $clog2(MAXNW) + 1;
  localparam int NCW   = $clog2(MAXNN) + 1;

  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;

  state_t           state;
  logic [2:0]       layer_cnt;
  logic [NCW-1:0]   neuron_cnt;
  logic [WCW-1:0]   word_cnt;

  // Index of the last weight word of a neuron in the given layer.
  function automatic logic [WCW-1:0] nw_last(input logic [2:0] l);
    case (l)
      3'd1:    nw_last = WCW'(NW1 - 1);
      3'd2:    nw_last = WCW'(NW2 - 1);
      3'd3:    nw_last = WCW'(NW3 - 1);
      default: nw_last = WCW'(NW4 - 1);
    endcase
  endfunction

  // Index of the last neuron in the given layer.
  function automatic logic [NCW-1:0] nn_last(input logic [2:0] l);
    case (l)
      3'd1:    nn_last = NCW'(NN1 - 1);
      3'd2:    nn_last = NCW'(NN2 - 1);
      3'd3:    nn_last = NCW'(NN3 - 1);
      default: nn_last = NCW'(NN4 - 1);
    endcase
  endfunction

  logic accept;
  assign accept = cfg_in_valid && cfg_in_ready;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state             <= IDLE;
      layer_cnt         <= '0;
      neuron_cnt        <= '0;
      word_cnt          <= '0;
      cfg_in_ready      <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
    end else begin
      // Strobes and the completion pulse last a single cycle.
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      done        <= 1'b0;

      case (state)
        IDLE: begin
          // abort beats a simultaneous start.
          if (start && !abort) begin
            state        <= WEIGHT;
            layer_cnt    <= 3'd1;
            neuron_cnt   <= '0;
            word_cnt     <= '0;
            aborted      <= 1'b0;
            cfg_in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end

        WEIGHT, BIAS: begin
          if (abort) begin
            // A word handshaken in the abort cycle is dropped.
            state        <= IDLE;
            aborted      <= 1'b1;
            cfg_in_ready <= 1'b0;
            busy         <= 1'b0;
          end else if (accept) begin
            config_layer_num  <= 32'(layer_cnt);
            config_neuron_num <= 32'(neuron_cnt);
            if (state == WEIGHT) begin
              weightValid <= 1'b1;
              weightValue <= cfg_in_data;
              if (word_cnt == nw_last(layer_cnt)) begin
                word_cnt <= '0;
                state    <= BIAS;
              end else begin
                word_cnt <= word_cnt + WCW'(1);
              end
            end else begin
              biasValid <= 1'b1;
              biasValue <= cfg_in_data;
              if (neuron_cnt < nn_last(layer_cnt)) begin
                neuron_cnt <= neuron_cnt + NCW'(1);
                state      <= WEIGHT;
              end else if (layer_cnt < 3'(NL)) begin
                layer_cnt  <= layer_cnt + 3'd1;
                neuron_cnt <= '0;
                state      <= WEIGHT;
              end else begin
                // Final bias: done rises together with its strobe.
                state        <= DONE;
                done         <= 1'b1;
                cfg_in_ready <= 1'b0;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_weight_loader.sv
module tb_nn_weight_loader;
  localparam int NL = 2, NN1 = 2, NW1 = 3, NN2 = 1, NW2 = 2, DW = 32;
  localparam int TOTAL = NN1 * (NW1 + 1) + NN2 * (NW2 + 1);

  logic          clk;
  logic          rst_n;
  logic          start, abort;
  logic [DW-1:0] cfg_in_data;
  logic          cfg_in_valid, cfg_in_ready;
  logic [31:0]   config_layer_num, config_neuron_num;
  logic [DW-1:0] weightValue, biasValue;
  logic          weightValid, biasValid, busy, done, aborted;

  nn_weight_loader #(
    .NL(NL), .NN1(NN1), .NW1(NW1), .NN2(NN2), .NW2(NW2),
    .NN3(1), .NW3(1), .NN4(1), .NW4(1), .DW(DW)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .start(start), .abort(abort),
    .cfg_in_data(cfg_in_data), .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .weightValue(weightValue), .weightValid(weightValid),
    .biasValue(biasValue), .biasValid(biasValid),
    .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference image layout: which layer/neuron/kind each stream word is.
  typedef struct {bit bias; int layer; int neuron; bit last;} slot_t;
  typedef struct {bit bias; int layer; int neuron; logic [31:0] value; bit last;} exp_t;
  slot_t img[$];
  exp_t  sb[$];

  int total = 0, bad = 0;
  bit m_ready = 0, m_done_cyc = 0, m_aborted = 0;
  int k = 0, exp_dones = 0, seen_dones = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic build_image();
    for (int l = 1; l <= NL; l++) begin
      int nn, nw;
      nn = (l == 1) ? NN1 : NN2;
      nw = (l == 1) ? NW1 : NW2;
      for (int n = 0; n < nn; n++) begin
        for (int w = 0; w < nw; w++) img.push_back('{1'b0, l, n, 1'b0});
        img.push_back('{1'b1, l, n, (l == NL) && (n == nn - 1)});
      end
    end
  endtask

  // One clock of stimulus; model state advances per the loader's rules.
  task automatic step(input bit v, input logic [31:0] d, input bit st, input bit ab, output bit acc);
    bit was_done;
    cfg_in_valid = v; cfg_in_data = d; start = st; abort = ab;
    check("ready", 32'(cfg_in_ready), 32'(m_ready));
    check("busy", 32'(busy), 32'(m_ready || m_done_cyc));
    check("aborted", 32'(aborted), 32'(m_aborted));
    acc = v && m_ready && !ab;
    was_done = m_done_cyc;
    m_done_cyc = 0;
    if (acc) begin
      sb.push_back('{img[k].bias, img[k].layer, img[k].neuron, d, img[k].last});
      k++;
      if (k == TOTAL) begin
        m_ready = 0; m_done_cyc = 1; exp_dones++;
      end
    end else if (ab && m_ready) begin
      m_ready = 0; m_aborted = 1;
    end else if (st && !ab && !m_ready && !was_done) begin
      m_ready = 1; k = 0; m_aborted = 0;
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(cfg_in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_aborted"}, 32'(aborted), 0);
    check({tag, "_wvld"}, 32'(weightValid), 0);
    check({tag, "_bvld"}, 32'(biasValid), 0);
    check({tag, "_layer"}, config_layer_num, 0);
    check({tag, "_neuron"}, config_neuron_num, 0);
    check({tag, "_wval"}, weightValue, 0);
    check({tag, "_bval"}, biasValue, 0);
  endtask

  // gap: 0 back-to-back, 1 alternate cycles, 2 random.
  task automatic run_load(input int gap, input bit rnd, input int abort_w,
                          input int start_w, input int reset_w);
    bit acc, v, ab, st;
    int w, cyc;
    logic [31:0] d;
    w = 0; cyc = 0;
    step(0, 0, 1, 0, acc);
    while (w < TOTAL) begin
      if (cyc >= 200) begin
        total++; bad++;
        $display("FAIL load_timeout actual=%0d required=<200", cyc);
        break;
      end
      if (w == reset_w) begin
        step(0, 0, 0, 0, acc);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        check("rst_sb_empty", 32'(sb.size()), 0);
        m_ready = 0; m_done_cyc = 0; m_aborted = 0; k = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, acc);
        check("rst_dones", 32'(seen_dones), 32'(exp_dones));
        return;
      end
      v  = (gap == 0) ? 1'b1 : (gap == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      d  = rnd ? $urandom : 32'(w + 1);
      ab = v && (w == abort_w);
      st = v && (w == start_w);
      step(v, d, st, ab, acc);
      cyc++;
      if (ab) break;
      if (acc) w++;
    end
    step(0, 0, 0, 0, acc);
    step(0, 0, 0, 0, acc);
    check("dones", 32'(seen_dones), 32'(exp_dones));
    check("sb_drained", 32'(sb.size()), 0);
  endtask

  // Monitor: every strobe is matched against the next expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("strobe_excl", 32'(weightValid & biasValid), 0);
      if (weightValid || biasValid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe actual=strobe required=none");
        end else begin
          e = sb.pop_front();
          check("kind", 32'(biasValid), 32'(e.bias));
          check("layer", config_layer_num, 32'(e.layer));
          check("neuron", config_neuron_num, 32'(e.neuron));
          check("value", biasValid ? biasValue : weightValue, e.value);
          check("done_with_last", 32'(done), 32'(e.last));
        end
      end else begin
        check("done_no_strobe", 32'(done), 0);
      end
      if (done) seen_dones++;
    end
  end

  initial begin
    bit acc;
    build_image();
    rst_n = 1'b0; start = 0; abort = 0; cfg_in_valid = 0; cfg_in_data = '0;
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back 1..11, then the held bus values after completion.
    run_load(0, 0, -1, -1, -1);
    check("hold_layer", config_layer_num, 2);
    check("hold_neuron", config_neuron_num, 0);
    check("hold_bias", biasValue, 11);
    check("hold_weight", weightValue, 10);

    run_load(1, 0, -1, -1, -1);      // valid toggled every other cycle
    run_load(0, 0, 5, -1, -1);       // abort while word 6 is offered
    check("abort_flag", 32'(aborted), 1);
    run_load(0, 0, -1, -1, -1);      // fresh load clears aborted
    run_load(0, 0, -1, 4, -1);       // start pulsed mid-load
    run_load(0, 0, -1, -1, 7);       // async reset after word 7

    // start and abort together in IDLE.
    step(0, 0, 1, 1, acc);
    step(0, 0, 0, 0, acc);
    check("sa_busy", 32'(busy), 0);
    check("sa_ready", 32'(cfg_in_ready), 0);

    for (int i = 0; i < 4; i++) run_load(2, 1, -1, -1, -1);
    run_load(2, 1, int'($urandom_range(0, TOTAL - 1)), -1, -1);
    run_load(2, 1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1);
  end
endmodule

// File: doc/nn_weight_loader.md
Name: nn_weight_loader

Overview:
- Sequencer that streams the network's weight and bias image into the layer array.
- Accepts a flat word stream (AXI-Stream style) and drives the shared configuration bus (`config_layer_num`, `config_neuron_num`, `weightValue`/`weightValid`, `biasValue`/`biasValid`) that every layer decodes.
- Removes the per-word AXI-Lite writes from the host. Sits between a DMA stream port and the layer instances, in parallel with the AXI-Lite wrapper's config outputs; the top selects the source.

Parameters:
- NL, 4, number of layers sequenced (1..4).
- NN1, 30, neurons in layer 1.
- NW1, 784, weights per neuron in layer 1.
- NN2, 30, neurons in layer 2.
- NW2, 30, weights per neuron in layer 2.
- NN3, 10, neurons in layer 3.
- NW3, 30, weights per neuron in layer 3.
- NN4, 10, neurons in layer 4.
- NW4, 10, weights per neuron in layer 4.
- DW, 32, config word width.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load.
- abort  in  1  one-cycle pulse; cancels a load.
- cfg_in_data  in  DW  stream word.
- cfg_in_valid  in  1  stream word valid.
- cfg_in_ready  out  1  loader accepts a word.
- config_layer_num  out  32  target layer, 1-based.
- config_neuron_num  out  32  target neuron, 0-based.
- weightValue  out  DW  weight word.
- weightValid  out  1  one-cycle weight strobe.
- biasValue  out  DW  bias word.
- biasValid  out  1  one-cycle bias strobe.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse; load completed.
- aborted  out  1  sticky; last load was cancelled.

Behaviour:
- Reset (s_axi_aresetn low, asynchronous):
  - All outputs 0, counters 0, state IDLE.
  - Reset mid-load discards the load; no done, aborted stays 0.
- Stream order:
  - For layer L = 1..NL, for neuron n = 0..NN_L-1: NW_L weight words, then 1 bias word.
  - Total words = sum over L of NN_L*(NW_L+1).
- States: IDLE, WEIGHT, BIAS, DONE.
- IDLE:
  - cfg_in_ready=0, busy=0.
  - start -> WEIGHT; layer_cnt=1, neuron_cnt=0, word_cnt=0, aborted cleared.
- WEIGHT:
  - cfg_in_ready=1, busy=1.
  - Each accepted word (valid&&ready): word_cnt++.
  - When word_cnt==NW_L-1 on accept -> BIAS, word_cnt=0.
- BIAS:
  - cfg_in_ready=1.
  - On accept, if neuron_cnt<NN_L-1: neuron_cnt++, -> WEIGHT.
  - Else if layer_cnt<NL: layer_cnt++, neuron_cnt=0, -> WEIGHT.
  - Else -> DONE.
- DONE:
  - cfg_in_ready=0, busy=1.
  - done=1 for exactly this one cycle; -> IDLE next cycle.
- Output timing:
  - Registered, latency 1 cycle from accept.
  - The cycle after a WEIGHT accept: weightValid=1, weightValue=word, config_layer_num/config_neuron_num = the layer/neuron the word belongs to.
  - Bias accepts behave the same way, on biasValid/biasValue.
  - weightValid and biasValid are never high together.
  - The final biasValid and done are asserted in the same cycle.
- Hold rules:
  - config_layer_num/neuron_num hold their last value between strobes and after completion, until the next load or reset.
  - weightValue/biasValue hold their last value.
- Flow control:
  - Gaps in cfg_in_valid stall the sequence indefinitely; no strobe in gap cycles.
- abort:
  - In WEIGHT/BIAS: -> IDLE next cycle, aborted=1, no done, no further strobes. A word accepted in the same cycle is dropped (no strobe).
  - In IDLE/DONE: ignored.
- start:
  - Ignored while busy.
  - start and abort in the same IDLE cycle: abort wins, stay IDLE.
- Words offered in IDLE/DONE are not accepted (ready=0).
- Counter widths: word_cnt >= clog2(max NW)+1, neuron_cnt >= clog2(max NN)+1; zero-extended to 32 bits on outputs.

Test Plan (bench uses NL=2, NN1=2, NW1=3, NN2=1, NW2=2; 11 words):
- Reset, start, 11 back-to-back words 0x1..0xB:
  - weight strobes: (1,0) 1,2,3; (1,1) 5,6,7; (2,0) 9,10.
  - bias strobes: (1,0)=4, (1,1)=8, (2,0)=11.
  - done pulses with the bias-11 strobe; ready=0 after.
- Same stream with cfg_in_valid toggled every other cycle: identical strobe sequence, one strobe per accepted word, no strobes in gaps, done once.
- Abort on the cycle word 6 is offered: no strobe for word 6, aborted=1, busy=0, done never asserts; a new start then runs a full 11-word load and clears aborted.
- start pulsed mid-load (after word 4): ignored; counters unaffected; load completes normally at word 11.
- s_axi_aresetn low asynchronously after word 7: all outputs 0 immediately, state IDLE; no done.
- start and abort in the same IDLE cycle: stays IDLE, busy=0, ready=0.
